mem_read_d_agen: RTL and testbench

//  Next-generation read-address generator for the D operand buffer of the N1 x N2 systolic array.

---
 rtl/mem_read_d_agen.sv | 193 +++++++++++++++++++
 tb/tb_mem_read_d_agen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_d_agen.sv
// D operand buffer read-address generator for the N1 x N2 systolic array.
// Optional MRD_AGEN_STALL_CNT_EN adds a saturating stall_cnt output.
module mem_read_d_agen #(
  parameter int N1           = 4,
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       cfg_base,
  input  logic [MATRIXSIZE_W-1:0] cfg_block_width,
  input  logic [MATRIXSIZE_W-1:0] cfg_block_num,
  input  logic [MATRIXSIZE_W-1:0] cfg_phases,
  input  logic [ADDR_W-1:0]       cfg_blk_stride,
  input  logic                    cfg_rev,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [MATRIXSIZE_W-1:0] out_block_idx,
  output logic [N1-1:0]           out_act,
  output logic                    out_last
`ifdef MRD_AGEN_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int MW = MATRIXSIZE_W;
  localparam int AW = ADDR_W;
  localparam logic [MW-1:0] MC_MASK = MW'(N2 - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [MW-1:0] bw_q, bn_q, ph_q;
  logic [AW-1:0] base_q, stride_q;
  logic          rev_q;

  logic [MW-1:0] col, blk, row, ph;
  logic [AW-1:0] blk_off, offset;

  logic [MW-1:0] n_col, n_blk, n_row, n_ph;
  logic [AW-1:0] n_blk_off, n_off;
  logic          n_last;
  logic          cfg_bad, hs, start_last;

  // N2 is a power of 2, so the reversed index grp+N2-1-mc is col ^ (N2-1)
  function automatic logic [AW-1:0] idx_of(input logic [MW-1:0] c,
                                           input logic r);
    return AW'(r ? (c ^ MC_MASK) : c);
  endfunction

  assign cfg_bad = (cfg_block_width == '0)
                || ((cfg_block_width & MC_MASK) != '0)
                || (cfg_block_num == '0)
                || (cfg_phases == '0);

  assign hs = out_valid & out_ready;

  assign start_last = (cfg_block_width == MW'(1))
                   && (cfg_block_num == MW'(1))
                   && (N1 == 1)
                   && (cfg_phases == MW'(1));

  always_comb begin
    n_col     = col;
    n_blk     = blk;
    n_row     = row;
    n_ph      = ph;
    n_blk_off = blk_off;
    n_off     = offset;
    if (col != bw_q - MW'(1)) begin
      n_col = col + MW'(1);
    end else begin
      n_col = '0;
      if (blk != bn_q - MW'(1)) begin
        n_blk     = blk + MW'(1);
        n_blk_off = blk_off + stride_q;
      end else begin
        n_blk     = '0;
        n_blk_off = '0;
        if (row != MW'(N1 - 1)) begin
          n_row = row + MW'(1);
        end else begin
          n_row = '0;
          n_ph  = ph + MW'(1);
          n_off = offset + AW'(bw_q);
        end
      end
    end
    n_last = (n_col == bw_q - MW'(1))
          && (n_blk == bn_q - MW'(1))
          && (n_row == MW'(N1 - 1))
          && (n_ph == ph_q - MW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bw_q          <= '0;
      bn_q          <= '0;
      ph_q          <= '0;
      base_q        <= '0;
      stride_q      <= '0;
      rev_q         <= 1'b0;
      col           <= '0;
      blk           <= '0;
      row           <= '0;
      ph            <= '0;
      blk_off       <= '0;
      offset        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      out_valid     <= 1'b0;
      out_addr      <= '0;
      out_block_idx <= '0;
      out_act       <= '0;
      out_last      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && cfg_bad) begin
            err <= 1'b1;
          end else if (start) begin
            state         <= RUN;
            bw_q          <= cfg_block_width;
            bn_q          <= cfg_block_num;
            ph_q          <= cfg_phases;
            base_q        <= cfg_base;
            stride_q      <= cfg_blk_stride;
            rev_q         <= cfg_rev;
            col           <= '0;
            blk           <= '0;
            row           <= '0;
            ph            <= '0;
            blk_off       <= '0;
            offset        <= '0;
            busy          <= 1'b1;
            out_valid     <= 1'b1;
            out_addr      <= cfg_base + idx_of('0, cfg_rev);
            out_block_idx <= '0;
            out_act       <= N1'(1);
            out_last      <= start_last;
          end
        end
        RUN: begin
          if (hs && out_last) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            out_valid <= 1'b0;
            out_act   <= '0;
            out_last  <= 1'b0;
          end else if (hs) begin
            col           <= n_col;
            blk           <= n_blk;
            row           <= n_row;
            ph            <= n_ph;
            blk_off       <= n_blk_off;
            offset        <= n_off;
            out_addr      <= base_q + n_blk_off + n_off
                           + idx_of(n_col, rev_q);
            out_block_idx <= n_blk;
            out_act       <= N1'(1) << n_row;
            out_last      <= n_last;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MRD_AGEN_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start && !cfg_bad) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_read_d_agen.sv
// Bench for mem_read_d_agen: directed cases plus randomized jobs and ready.
// Expected beats come from a nested-loop address model.
module tb_mem_read_d_agen;

  localparam int N1 = 2;
  localparam int N2 = 2;
  localparam int MW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst, start, cfg_rev, out_ready;
  logic [AW-1:0] cfg_base, cfg_blk_stride;
  logic [MW-1:0] cfg_block_width, cfg_block_num, cfg_phases;
  logic          busy, done, err, out_valid, out_last;
  logic [AW-1:0] out_addr;
  logic [MW-1:0] out_block_idx;
  logic [N1-1:0] out_act;
`ifdef MRD_AGEN_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  typedef logic [AW+N1+MW:0] beat_t;
  beat_t exp_q[$];
  int    exp_stalls;
  int    vectors = 0;
  int    miscompares = 0;

  mem_read_d_agen #(
    .N1(N1), .N2(N2), .MATRIXSIZE_W(MW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base(cfg_base), .cfg_block_width(cfg_block_width),
    .cfg_block_num(cfg_block_num), .cfg_phases(cfg_phases),
    .cfg_blk_stride(cfg_blk_stride), .cfg_rev(cfg_rev),
    .busy(busy), .done(done), .err(err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_block_idx(out_block_idx),
    .out_act(out_act), .out_last(out_last)
`ifdef MRD_AGEN_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model(input int bw, input int bn, input int ph,
                       input int stride, input int base, input int rev);
    exp_q.delete();
    for (int p = 0; p < ph; p++)
      for (int r = 0; r < N1; r++)
        for (int b = 0; b < bn; b++)
          for (int c = 0; c < bw; c++) begin
            int mc, idx, a;
            bit last;
            mc = c % N2;
            idx = rev ? (c - mc + N2 - 1 - mc) : c;
            a = (base + b * stride + p * bw + idx) % (1 << AW);
            last = (p == ph - 1) && (r == N1 - 1)
                && (b == bn - 1) && (c == bw - 1);
            exp_q.push_back({AW'(a), N1'(1 << r), MW'(b), last});
          end
  endtask

  task automatic job(input int bw, input int bn, input int ph,
                     input int stride, input int base, input int rev);
    model(bw, bn, ph, stride, base, rev);
    cfg_block_width = MW'(bw);
    cfg_block_num   = MW'(bn);
    cfg_phases      = MW'(ph);
    cfg_blk_stride  = AW'(stride);
    cfg_base        = AW'(base);
    cfg_rev         = rev[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int mode, input int inject);
    int cyc, beat, hold;
    cyc = 0;
    beat = 0;
    hold = 0;
    exp_stalls = 0;
    while (exp_q.size() > 0 && cyc < 4000) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (beat == 2 && hold < 3) begin
            out_ready = 1'b0;
            hold++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      start = (inject != 0) && (beat == 3);
      if (start) begin
        cfg_block_width = MW'(3);
        cfg_base = AW'($urandom);
      end
      vectors++;
      assert ({busy, out_valid, err, done, out_addr, out_act,
               out_block_idx, out_last} === {4'b1100, exp_q[0]})
      else begin
        miscompares++;
        $error("FAIL beat%0d got=%h exp=%h", beat,
               {busy, out_valid, err, done, out_addr, out_act,
                out_block_idx, out_last}, {4'b1100, exp_q[0]});
      end
      if (!out_ready) exp_stalls++;
      if (out_ready) begin
        void'(exp_q.pop_front());
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (exp_q.size() > 0) begin
      miscompares++;
      $error("FAIL timeout got=%0d beats left exp=0", exp_q.size());
    end
    vectors++;
    assert ({busy, out_valid, done} === 3'b001)
    else begin
      miscompares++;
      $error("FAIL done got=%b exp=001", {busy, out_valid, done});
    end
`ifdef MRD_AGEN_STALL_CNT_EN
    vectors++;
    assert (stall_cnt === 32'(exp_stalls))
    else begin
      miscompares++;
      $error("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, exp_stalls);
    end
`endif
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    assert ({busy, done, err, out_valid, out_addr, out_act,
             out_block_idx, out_last} === '0)
    else begin
      miscompares++;
      $error("FAIL %s got=%h exp=0", tag,
             {busy, done, err, out_valid, out_addr, out_act,
              out_block_idx, out_last});
    end
  endtask

  task automatic cfg_err(input int bw, input int bn, input int ph);
    @(negedge clk);
    job(bw, bn, ph, 0, 0, 0);
    vectors++;
    assert ({err, busy, out_valid} === 3'b100)
    else begin
      miscompares++;
      $error("FAIL err_pulse got=%b exp=100", {err, busy, out_valid});
    end
    @(negedge clk);
    vectors++;
    assert ({err, busy, out_valid} === 3'b000)
    else begin
      miscompares++;
      $error("FAIL err_clear got=%b exp=000", {err, busy, out_valid});
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    cfg_rev = 1'b0;
    cfg_base = '0;
    cfg_blk_stride = '0;
    cfg_block_width = '0;
    cfg_block_num = '0;
    cfg_phases = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    @(negedge clk);
    job(4, 1, 1, 0, 0, 1);
    run(0, 0);
    job(2, 1, 2, 0, 'h10, 0);
    run(0, 0);
    @(negedge clk);
    job(2, 2, 1, 8, 0, 1);
    run(0, 1);
    @(negedge clk);
    job(4, 1, 1, 0, 0, 1);
    run(2, 0);

    cfg_err(3, 1, 1);
    cfg_err(2, 0, 1);
    cfg_err(0, 1, 1);
    cfg_err(2, 1, 0);

    @(negedge clk);
    job(4, 2, 2, 5, 0, 0);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("rst_mid");
    @(negedge clk);
    check_zero("no_done");

    @(negedge clk);
    job(2, 1, 1, 0, 'hFFF, 0);
    run(0, 0);

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      job(2 * $urandom_range(1, 3), $urandom_range(1, 3),
          $urandom_range(1, 3), $urandom_range(0, 4095),
          $urandom_range(0, 4095), $urandom_range(0, 1));
      run(1, k % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
